pid_multi_ch: RTL and testbench



---
 rtl/pid_multi_ch.sv | 390 +++++++++++++++++++++++++++++++++++++++
 tb/tb_pid_multi_ch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_multi_ch.sv
// pid_multi_ch: NUM_CH PID loops that share one time-multiplexed multiplier,
// configured and observed through an Avalon-MM slave register file.
//
// Each sample_tick starts a round. Every channel in turn goes through
// ERR -> PROP -> INTG -> DERV -> SUM. All outputs are then published
// together in DONE.
//
// Optional build macro:
//   PID_ANTIWINDUP_EN - conditional integration. When defined, the integrator
//                       is not updated on a sample whose unclamped output
//                       falls outside the DATA_W range.
//
// Ports:
//   clk_clk, reset_reset_n   clock, asynchronous active-low reset
//   avs_*                    Avalon-MM slave (6-bit word address, readdata
//                            one cycle after avs_read, no waitrequest)
//   sample_tick              one-cycle pulse that starts a round
//   meas_in                  packed signed measurements, ch0 in the LSBs
//   ctrl_out                 packed signed controller outputs
//   out_valid                one-cycle pulse when ctrl_out updates
//   busy                     a round is in progress
//   irq                      done_flag & irq_en
module pid_multi_ch #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [5:0]               avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    output logic [31:0]              avs_readdata,
    input  logic                     sample_tick,
    input  logic [NUM_CH*DATA_W-1:0] meas_in,
    output logic [NUM_CH*DATA_W-1:0] ctrl_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     irq
);

    localparam int EW  = DATA_W + 1;              // error width
    localparam int PW  = COEF_W + DATA_W + 2;     // product width
    localparam int CIW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] Y_MIN = ~Y_MAX;

    typedef enum logic [2:0] {StIdle, StErr, StProp, StIntg, StDerv, StSum, StDone} state_e;

    // Register file
    logic signed [DATA_W-1:0] sp_q    [NUM_CH];
    logic signed [DATA_W-1:0] sp_d    [NUM_CH];
    logic signed [COEF_W-1:0] kp_q    [NUM_CH];
    logic signed [COEF_W-1:0] kp_d    [NUM_CH];
    logic signed [COEF_W-1:0] ki_q    [NUM_CH];
    logic signed [COEF_W-1:0] ki_d    [NUM_CH];
    logic signed [COEF_W-1:0] kd_q    [NUM_CH];
    logic signed [COEF_W-1:0] kd_d    [NUM_CH];
    logic [NUM_CH-1:0]        en_q, en_d;
    logic                     overrun_q, overrun_d;
    logic                     done_q, done_d;
    logic                     irq_en_q, irq_en_d;

    // Per-channel loop state
    logic signed [ACC_W-1:0]  integ_q  [NUM_CH];
    logic signed [ACC_W-1:0]  integ_d  [NUM_CH];
    logic signed [EW-1:0]     eprev_q  [NUM_CH];
    logic signed [EW-1:0]     eprev_d  [NUM_CH];
    logic signed [DATA_W-1:0] shadow_q [NUM_CH];
    logic signed [DATA_W-1:0] shadow_d [NUM_CH];
    logic signed [DATA_W-1:0] out_q    [NUM_CH];
    logic signed [DATA_W-1:0] out_d    [NUM_CH];
    logic signed [DATA_W-1:0] meas_q   [NUM_CH];
    logic signed [DATA_W-1:0] meas_d   [NUM_CH];

    // Round sequencing and datapath
    state_e                   state_q, state_d;
    logic [CIW-1:0]           ch_q, ch_d;
    logic signed [EW-1:0]     e_q, e_d;
    logic signed [COEF_W-1:0] kp_s_q, kp_s_d, ki_s_q, ki_s_d, kd_s_q, kd_s_d;
    logic                     en_s_q, en_s_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  integ_n_q, integ_n_d;
    logic                     busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic [31:0]              rdata_q, rdata_d;

    // Shared multiplier and combinational arithmetic
    logic signed [COEF_W-1:0] mul_a;
    logic signed [DATA_W+1:0] mul_b;
    logic signed [PW-1:0]     mul_p;
    logic signed [ACC_W-1:0]  mul_ext;
    logic signed [EW-1:0]     eprev_cur;
    logic signed [ACC_W-1:0]  integ_cur;
    logic signed [DATA_W+1:0] e_diff;
    logic signed [ACC_W:0]    isum;
    logic signed [ACC_W-1:0]  integ_sat;
    logic signed [ACC_W:0]    tot;
    logic signed [ACC_W:0]    ysh;
    logic                     y_hi, y_lo;
    logic signed [DATA_W-1:0] y_sat;

    // Bus decode
    logic [2:0]               a_ch;
    logic [2:0]               a_off;
    logic [CIW-1:0]           a_idx;
    logic                     a_in_ch;
    logic                     a_glb;
    logic signed [63:0]       integ_rd_w;
    logic [31:0]              rd_mux;
    logic                     ovr_set, done_set;
    logic                     unused_ok;

    assign a_ch    = avs_address[5:3];
    assign a_off   = avs_address[2:0];
    assign a_idx   = avs_address[3+CIW-1:3];
    assign a_in_ch = int'(a_ch) < NUM_CH;
    assign a_glb   = (a_ch == 3'd7);

    assign eprev_cur = eprev_q[ch_q];
    assign integ_cur = integ_q[ch_q];
    assign e_diff    = {e_q[EW-1], e_q} - {eprev_cur[EW-1], eprev_cur};

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            StProp: begin
                mul_a = kp_s_q;
                mul_b = {e_q[EW-1], e_q};
            end
            StIntg: begin
                mul_a = ki_s_q;
                mul_b = {e_q[EW-1], e_q};
            end
            StDerv: begin
                mul_a = kd_s_q;
                mul_b = e_diff;
            end
            default: ;
        endcase
    end

    assign mul_p   = mul_a * mul_b;
    assign mul_ext = ACC_W'(mul_p);

    // Integrator update, clamped to the accumulator range
    assign isum      = {integ_cur[ACC_W-1], integ_cur} + {mul_ext[ACC_W-1], mul_ext};
    assign integ_sat = (isum[ACC_W] != isum[ACC_W-1]) ?
                       {isum[ACC_W], {(ACC_W-1){~isum[ACC_W]}}} : isum[ACC_W-1:0];

    // Output: (acc + integ_n) >>> FRAC_BITS, clamped to DATA_W
    assign tot   = {acc_q[ACC_W-1], acc_q} + {integ_n_q[ACC_W-1], integ_n_q};
    assign ysh   = tot >>> FRAC_BITS;
    assign y_hi  = ysh > Y_MAX;
    assign y_lo  = ysh < Y_MIN;
    assign y_sat = y_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                   y_lo ? {1'b1, {(DATA_W-1){1'b0}}} : ysh[DATA_W-1:0];

    always_comb begin
        sp_d        = sp_q;
        kp_d        = kp_q;
        ki_d        = ki_q;
        kd_d        = kd_q;
        en_d        = en_q;
        integ_d     = integ_q;
        eprev_d     = eprev_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        meas_d      = meas_q;
        state_d     = state_q;
        ch_d        = ch_q;
        e_d         = e_q;
        kp_s_d      = kp_s_q;
        ki_s_d      = ki_s_q;
        kd_s_d      = kd_s_q;
        en_s_d      = en_s_q;
        acc_d       = acc_q;
        integ_n_d   = integ_n_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        done_set    = 1'b0;
        ovr_set     = sample_tick && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (sample_tick) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        meas_d[c] = meas_in[c*DATA_W +: DATA_W];
                    end
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = StErr;
                end
            end
            StErr: begin
                e_d     = {sp_q[ch_q][DATA_W-1], sp_q[ch_q]}
                        - {meas_q[ch_q][DATA_W-1], meas_q[ch_q]};
                kp_s_d  = kp_q[ch_q];
                ki_s_d  = ki_q[ch_q];
                kd_s_d  = kd_q[ch_q];
                en_s_d  = en_q[ch_q];
                state_d = StProp;
            end
            StProp: begin
                acc_d   = mul_ext;
                state_d = StIntg;
            end
            StIntg: begin
                integ_n_d = integ_sat;
                state_d   = StDerv;
            end
            StDerv: begin
                acc_d   = acc_q + mul_ext;
                state_d = StSum;
            end
            StSum: begin
                if (en_s_q) begin
                    shadow_d[ch_q] = y_sat;
                    eprev_d[ch_q]  = e_q;
`ifdef PID_ANTIWINDUP_EN
                    if (!(y_hi || y_lo)) begin
                        integ_d[ch_q] = integ_n_q;
                    end
`else
                    integ_d[ch_q] = integ_n_q;
`endif
                end else begin
                    shadow_d[ch_q] = '0;
                    integ_d[ch_q]  = '0;
                    eprev_d[ch_q]  = '0;
                end
                if (ch_q == CIW'(NUM_CH - 1)) begin
                    state_d = StDone;
                end else begin
                    ch_d    = ch_q + CIW'(1);
                    state_d = StErr;
                end
            end
            StDone: begin
                out_d       = shadow_q;
                out_valid_d = 1'b1;
                done_set    = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Bus writes come after the round update so that clr_integ beats SUM
        if (avs_write && a_in_ch) begin
            case (a_off)
                3'd0: sp_d[a_idx] = avs_writedata[DATA_W-1:0];
                3'd1: kp_d[a_idx] = avs_writedata[COEF_W-1:0];
                3'd2: ki_d[a_idx] = avs_writedata[COEF_W-1:0];
                3'd3: kd_d[a_idx] = avs_writedata[COEF_W-1:0];
                3'd6: begin
                    en_d[a_idx] = avs_writedata[0];
                    if (avs_writedata[1]) begin
                        integ_d[a_idx] = '0;
                        eprev_d[a_idx] = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status bits: a hardware set in the same cycle beats the W1C clear
    always_comb begin
        overrun_d = overrun_q;
        done_d    = done_q;
        irq_en_d  = irq_en_q;
        if (avs_write && a_glb && (a_off == 3'd0)) begin
            overrun_d = overrun_q & ~avs_writedata[1];
            done_d    = done_q & ~avs_writedata[2];
        end
        if (avs_write && a_glb && (a_off == 3'd1)) begin
            irq_en_d = avs_writedata[0];
        end
        if (ovr_set) begin
            overrun_d = 1'b1;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    assign integ_rd_w = 64'(integ_q[a_idx]) >>> FRAC_BITS;

    always_comb begin
        rd_mux = '0;
        if (a_in_ch) begin
            case (a_off)
                3'd0: rd_mux = 32'(sp_q[a_idx]);
                3'd1: rd_mux = 32'(kp_q[a_idx]);
                3'd2: rd_mux = 32'(ki_q[a_idx]);
                3'd3: rd_mux = 32'(kd_q[a_idx]);
                3'd4: rd_mux = 32'(out_q[a_idx]);
                3'd5: rd_mux = integ_rd_w[31:0];
                3'd6: rd_mux = {31'd0, en_q[a_idx]};
                default: rd_mux = '0;
            endcase
        end else if (a_glb) begin
            case (a_off)
                3'd0: rd_mux = {29'd0, done_q, overrun_q, busy_q};
                3'd1: rd_mux = {31'd0, irq_en_q};
                default: rd_mux = '0;
            endcase
        end
        rdata_d = avs_read ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sp_q[c]     <= '0;
                kp_q[c]     <= '0;
                ki_q[c]     <= '0;
                kd_q[c]     <= '0;
                integ_q[c]  <= '0;
                eprev_q[c]  <= '0;
                shadow_q[c] <= '0;
                out_q[c]    <= '0;
                meas_q[c]   <= '0;
            end
            en_q        <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            state_q     <= StIdle;
            ch_q        <= '0;
            e_q         <= '0;
            kp_s_q      <= '0;
            ki_s_q      <= '0;
            kd_s_q      <= '0;
            en_s_q      <= 1'b0;
            acc_q       <= '0;
            integ_n_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sp_q        <= sp_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            kd_q        <= kd_d;
            integ_q     <= integ_d;
            eprev_q     <= eprev_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            meas_q      <= meas_d;
            en_q        <= en_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            e_q         <= e_d;
            kp_s_q      <= kp_s_d;
            ki_s_q      <= ki_s_d;
            kd_s_q      <= kd_s_d;
            en_s_q      <= en_s_d;
            acc_q       <= acc_d;
            integ_n_q   <= integ_n_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ctrl_out[c*DATA_W +: DATA_W] = out_q[c];
        end
    end

    assign avs_readdata = rdata_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign irq          = done_q & irq_en_q;

    assign unused_ok = ^{avs_writedata, integ_rd_w[63:32]};

endmodule

// File: tb/tb_pid_multi_ch.sv
module tb_pid_multi_ch;
    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int LAT       = 5 * NUM_CH + 1;
`ifdef PID_ANTIWINDUP_EN
    localparam bit AW = 1'b1;
`else
    localparam bit AW = 1'b0;
`endif

    logic                     clk_clk = 1'b0;
    logic                     reset_reset_n = 1'b1;
    logic [5:0]               avs_address = '0;
    logic                     avs_read = 1'b0;
    logic                     avs_write = 1'b0;
    logic [31:0]              avs_writedata = '0;
    logic [31:0]              avs_readdata;
    logic                     sample_tick = 1'b0;
    logic [NUM_CH*DATA_W-1:0] meas_in = '0;
    logic [NUM_CH*DATA_W-1:0] ctrl_out;
    logic                     out_valid;
    logic                     busy;
    logic                     irq;

    pid_multi_ch #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .COEF_W(COEF_W),
        .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .sample_tick(sample_tick), .meas_in(meas_in), .ctrl_out(ctrl_out),
        .out_valid(out_valid), .busy(busy), .irq(irq)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Behavioural model state
    longint m_sp[NUM_CH], m_kp[NUM_CH], m_ki[NUM_CH], m_kd[NUM_CH];
    longint m_integ[NUM_CH], m_eprev[NUM_CH], m_out[NUM_CH], m_meas[NUM_CH];
    bit     m_en[NUM_CH];

    function automatic longint sat(input longint v, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_sp[c] = 0; m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0; m_en[c] = 0;
            m_integ[c] = 0; m_eprev[c] = 0; m_out[c] = 0;
        end
    endtask

    task automatic model_round();
        longint e, integ_n, raw;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!m_en[c]) begin
                m_out[c] = 0; m_integ[c] = 0; m_eprev[c] = 0;
            end else begin
                e       = m_sp[c] - m_meas[c];
                integ_n = sat(m_integ[c] + m_ki[c] * e, ACC_W);
                raw     = (m_kp[c] * e + m_kd[c] * (e - m_eprev[c]) + integ_n) >>> FRAC_BITS;
                m_out[c] = sat(raw, DATA_W);
                if (!(AW && raw != m_out[c])) m_integ[c] = integ_n;
                m_eprev[c] = e;
            end
        end
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge clk_clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(posedge clk_clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic set_ch(input int c, input longint sp, input longint kp, input longint ki,
                          input longint kd, input bit en);
        bus_wr(6'(8 * c + 0), 32'(sp));
        bus_wr(6'(8 * c + 1), 32'(kp));
        bus_wr(6'(8 * c + 2), 32'(ki));
        bus_wr(6'(8 * c + 3), 32'(kd));
        bus_wr(6'(8 * c + 6), {31'd0, en});
        m_sp[c] = sp; m_kp[c] = kp; m_ki[c] = ki; m_kd[c] = kd; m_en[c] = en;
    endtask

    task automatic clr_integ(input int c);
        bus_wr(6'(8 * c + 6), {30'd0, 1'b1, m_en[c]});
        m_integ[c] = 0; m_eprev[c] = 0;
    endtask

    task automatic drive_meas();
        for (int c = 0; c < NUM_CH; c++) meas_in[c*DATA_W +: DATA_W] = 16'(m_meas[c]);
    endtask

    task automatic run_round(input string tag);
        int cyc = 0;
        drive_meas();
        sample_tick = 1'b1;
        @(posedge clk_clk); #1;
        sample_tick = 1'b0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk_clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, LAT);
        model_round();
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("%s_out%0d", tag, c), $signed(ctrl_out[c*DATA_W +: DATA_W]), m_out[c]);
    endtask

    function automatic longint out0();
        return longint'($signed(ctrl_out[DATA_W-1:0]));
    endfunction

    logic [31:0] rd;
    int          pulses;

    initial begin
        model_reset();
        #2 reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;

        // Reset state
        check("rst_ctrl_out", longint'(ctrl_out), 0);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        check("rst_valid", out_valid, 0);
        bus_rd(6'h38, rd); check("rst_status", rd, 0);
        bus_rd(6'h01, rd); check("rst_kp0", rd, 0);

        // Proportional
        set_ch(0, 1000, 256, 0, 0, 1'b1);
        m_meas[0] = 400;
        run_round("prop");
        check("prop_600", out0(), 600);
        bus_rd(6'h04, rd); check("prop_reg", $signed(rd), 600);

        // Integral
        set_ch(0, 1000, 0, 128, 0, 1'b1);
        clr_integ(0);
        m_meas[0] = 900;
        for (int i = 0; i < 3; i++) begin
            run_round("integ");
            check($sformatf("integ_k%0d", i), out0(), 50 * (i + 1));
        end
        bus_rd(6'h05, rd); check("integ_reg", $signed(rd), 150);
        clr_integ(0);
        run_round("integ_clr");
        check("integ_clr_50", out0(), 50);

        // Derivative
        set_ch(0, 1000, 0, 0, 256, 1'b1);
        clr_integ(0);
        m_meas[0] = 900; run_round("derv1"); check("derv_100", out0(), 100);
        m_meas[0] = 700; run_round("derv2"); check("derv_200", out0(), 200);

        // Saturation
        set_ch(0, 1000, 32767, 0, 0, 1'b1);
        m_meas[0] = 0;    run_round("satp"); check("sat_pos", out0(), 32767);
        m_meas[0] = 2000; run_round("satn"); check("sat_neg", out0(), -32768);

        // Integrator windup
        set_ch(0, 20000, 0, 256, 0, 1'b1);
        clr_integ(0);
        m_meas[0] = 0;
        run_round("aw1"); check("aw_o1", out0(), 20000);
        bus_rd(6'h05, rd); check("aw_integ1", $signed(rd), 20000);
        run_round("aw2"); check("aw_o2", out0(), 32767);
        run_round("aw3"); check("aw_o3", out0(), 32767);
        bus_rd(6'h05, rd); check("aw_integ3", $signed(rd), AW ? 20000 : 60000);
        m_meas[0] = 20100;
        run_round("aw4"); check("aw_o4", out0(), AW ? 19900 : 32767);

        // Register map details
        bus_wr(6'h09, 32'hFFFF_FFFB);
        m_kp[1] = -5;
        bus_rd(6'h09, rd); check("kp_sext", $signed(rd), -5);
        bus_wr(6'h20, 32'h1234);
        bus_rd(6'h20, rd); check("oor_read", rd, 0);
        bus_rd(6'h07, rd); check("unmapped_read", rd, 0);

        // Randomised rounds on all channels
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_ch(c, longint'(int'($urandom_range(0, 16000))) - 8000,
                       longint'(int'($urandom_range(0, 1023))) - 512,
                       longint'(int'($urandom_range(0, 1023))) - 512,
                       longint'(int'($urandom_range(0, 1023))) - 512,
                       bit'($urandom_range(0, 3) != 0));
                if ($urandom_range(0, 3) == 0) clr_integ(c);
                m_meas[c] = longint'(int'($urandom_range(0, 16000))) - 8000;
            end
            run_round($sformatf("rnd%0d", r));
            begin
                int c = int'($urandom_range(0, NUM_CH - 1));
                bus_rd(6'(8 * c + 4), rd);
                check($sformatf("rnd%0d_outreg", r), $signed(rd), m_out[c]);
                bus_rd(6'(8 * c + 5), rd);
                check($sformatf("rnd%0d_integreg", r), $signed(rd),
                      longint'(int'(m_integ[c] >>> FRAC_BITS)));
            end
        end

        // Overrun: second tick five cycles into the round
        bus_wr(6'h38, 32'h6);
        bus_rd(6'h38, rd); check("status_clr", rd, 0);
        drive_meas();
        sample_tick = 1'b1; @(posedge clk_clk); #1; sample_tick = 1'b0;
        repeat (4) @(posedge clk_clk);
        #1 sample_tick = 1'b1; @(posedge clk_clk); #1; sample_tick = 1'b0;
        bus_rd(6'h38, rd); check("ovr_status_busy", rd, 3);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_clk); #1;
            if (out_valid) pulses++;
        end
        check("ovr_single_valid", pulses, 1);
        model_round();
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("ovr_out%0d", c), $signed(ctrl_out[c*DATA_W +: DATA_W]), m_out[c]);
        bus_rd(6'h38, rd); check("ovr_status_done", rd, 6);
        bus_wr(6'h38, 32'h2);
        bus_rd(6'h38, rd); check("ovr_w1c", rd, 4);

        // Interrupt
        bus_wr(6'h39, 32'h1);
        check("irq_on", irq, 1);
        bus_wr(6'h38, 32'h4);
        check("irq_off", irq, 0);

        // Reset in the middle of a round
        set_ch(0, 1000, 256, 0, 0, 1'b1);
        m_meas[0] = 400;
        run_round("pre");
        check("pre_irq", irq, 1);
        sample_tick = 1'b1; @(posedge clk_clk); #1; sample_tick = 1'b0;
        repeat (8) @(posedge clk_clk);
        #1 reset_reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_ctrl_out", longint'(ctrl_out), 0);
        check("mid_irq", irq, 0);
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_clk); #1;
            if (out_valid) pulses++;
        end
        check("mid_no_valid", pulses, 0);
        bus_rd(6'h01, rd); check("mid_kp0", rd, 0);
        bus_rd(6'h38, rd); check("mid_status", rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
